// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a 2-flop input synchronizer and a small receive FIFO.
// Frames are 8N1 by default; define UART_RX_PARITY_EN for 8E1 with an even-parity check.
module uart_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [15:0] baud_div_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        busy_o,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, next_state;

  logic        sync_q, rxs, rxs_prev, fall;
  logic [15:0] divisor, cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        cnt_zero;
  logic        load_start, load_bit, cnt_dec, shift_en;
  logic        push, frame_err, parity_bad;
  logic        frame_err_q, overrun_q;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, overrun;

  // rxs_prev is part of the edge detector: a start needs a genuine high-to-low
  // transition, so a line held low after a framing error cannot retrigger.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync_q   <= rx_i;
      rxs      <= sync_q;
      rxs_prev <= rxs;
    end
  end

  assign fall     = rxs_prev & ~rxs;
  assign cnt_zero = (cnt == 16'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err, parity_err_q;
`endif

  always_comb begin
    next_state = state;
    load_start = 1'b0;
    load_bit   = 1'b0;
    cnt_dec    = 1'b0;
    shift_en   = 1'b0;
    push       = 1'b0;
    frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          load_start = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!rxs) begin
            load_bit   = 1'b1;
            next_state = DATA;
          end else begin
            next_state = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_en = 1'b1;
          load_bit = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_zero) begin
          load_bit   = 1'b1;
          parity_err = (rxs != ^shift);
          next_state = STOP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_zero) begin
          if (rxs) push = ~parity_bad;
          else     frame_err = 1'b1;
          next_state = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The divisor is latched at the start edge so baud changes only affect later frames.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      divisor <= 16'd0;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (load_start) begin
        divisor <= baud_div_i;
        cnt     <= baud_div_i >> 1;
        bit_idx <= 3'd0;
      end else if (load_bit) begin
        cnt <= divisor - 16'd1;
      end else if (cnt_dec) begin
        cnt <= cnt - 16'd1;
      end
      if (shift_en) begin
        shift   <= {rxs, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err;
      if (load_start)      parity_bad_q <= 1'b0;
      else if (parity_err) parity_bad_q <= 1'b1;
    end
  end

  assign parity_bad   = parity_bad_q;
  assign parity_err_o = parity_err_q;
`else
  assign parity_bad   = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & rx_ready_i;
  assign wr_en   = push & (~full | pop);
  assign overrun = push & full & ~pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err;
      overrun_q   <= overrun;
    end
  end

  assign rx_valid_o  = ~empty;
  assign rx_data_o   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign busy_o      = (state != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
